// File: rtl/xfft_feeder_pkg.sv
// Shared types and constants for the FFT frame feeder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package xfft_feeder_pkg;

    // Run-level sequencing states of the feeder.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CFG   = 2'd1,
        DATA  = 2'd2,
        DRAIN = 2'd3
    } feeder_state_t;

    // Bit position of the forward/inverse flag inside the FFT config word.
    localparam int CFG_FWD_INV_BIT = 0;

    // Samples per transform frame.
    localparam int FRAME_LEN = 256;

    // Width of the per-frame beat counters and of the run-length frame counters.
    localparam int BEAT_CNT_W  = $clog2(FRAME_LEN);
    localparam int FRAME_CNT_W = 16;

endpackage

// File: rtl/xfft_result_mon.sv
// Result-stream pass-through with frame counting and optional frame-length check.
// Latency: 0 cycles on the data path; counters/len_err update on the handshake edge.
// Backpressure: s_axis_fft_tready follows r_axis_tready combinationally; never stalls itself.
//
// Build option: XFFT_FEEDER_LEN_CHECK_EN enables the result beat counter and len_err.
// Ports:
//   aclk, areset          clock, async active-high reset
//   count_en              count result beats/frames (low while the feeder is idle)
//   clear                 zero the counters and len_err at the start of a run
//   s_axis_fft_*          result stream from the FFT core
//   r_axis_*              forwarded result stream
//   frames_rcvd           result frames counted in this run
//   frame_tick            a counted result frame completes this cycle
//   len_err               sticky frame-length error
module xfft_result_mon
    import xfft_feeder_pkg::*;
`ifdef XFFT_FEEDER_LEN_CHECK_EN
#(
    parameter int P_NFFT_LOG2 = BEAT_CNT_W
)
`endif
(
    input  logic                   aclk,
    input  logic                   areset,
    input  logic                   count_en,
    input  logic                   clear,
    input  logic [63:0]            s_axis_fft_tdata,
    input  logic                   s_axis_fft_tvalid,
    output logic                   s_axis_fft_tready,
    input  logic                   s_axis_fft_tlast,
    output logic [63:0]            r_axis_tdata,
    output logic                   r_axis_tvalid,
    input  logic                   r_axis_tready,
    output logic                   r_axis_tlast,
    output logic [FRAME_CNT_W-1:0] frames_rcvd,
    output logic                   frame_tick,
    output logic                   len_err
);

    logic beat_hs;

    assign r_axis_tdata      = s_axis_fft_tdata;
    assign r_axis_tvalid     = s_axis_fft_tvalid;
    assign r_axis_tlast      = s_axis_fft_tlast;
    assign s_axis_fft_tready = r_axis_tready;

    // Results seen while idle are forwarded but not counted.
    assign beat_hs    = s_axis_fft_tvalid & r_axis_tready & count_en;
    // Only a tlast closes a frame; a 256-beat run without tlast is not a frame.
    assign frame_tick = beat_hs & s_axis_fft_tlast;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            frames_rcvd <= '0;
        end else if (clear) begin
            frames_rcvd <= '0;
        end else if (frame_tick) begin
            frames_rcvd <= frames_rcvd + 1'b1;
        end
    end

`ifdef XFFT_FEEDER_LEN_CHECK_EN
    localparam logic [P_NFFT_LOG2-1:0] LAST_BEAT = '1;

    logic [P_NFFT_LOG2-1:0] res_beat;
    logic                   at_last;

    assign at_last = (res_beat == LAST_BEAT);

    // tlast must coincide exactly with the last beat position; either mismatch
    // direction flags an error. tlast resyncs the beat counter so a short
    // frame does not corrupt the next one.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            res_beat <= '0;
            len_err  <= 1'b0;
        end else if (clear) begin
            res_beat <= '0;
            len_err  <= 1'b0;
        end else if (beat_hs) begin
            res_beat <= s_axis_fft_tlast ? '0 : res_beat + 1'b1;
            if (s_axis_fft_tlast != at_last) begin
                len_err <= 1'b1;
            end
        end
    end
`else
    assign len_err = 1'b0;
`endif

endmodule

// File: rtl/xfft_frame_feeder.sv
// Feeds config and 256-sample frames into an AXI-Stream FFT core and forwards its results.
// Latency: start->config valid 1 cycle; config handshake->data 1 cycle; data/result paths 0 cycles; last result->done 1 cycle.
// Backpressure: data and result paths pass tready through combinationally; config valid held until accepted.
//
// Build option: XFFT_FEEDER_LEN_CHECK_EN enables result frame-length checking (len_err).
// Ports:
//   aclk, areset               clock, async active-high reset
//   start/frame_num/fwd_inv    run request, sampled when idle
//   busy/done/len_err          run status
//   s_axis_*                   upstream complex samples {im, re}
//   m_axis_config_*            one-shot FFT config word
//   m_axis_data_*              samples to the FFT, tlast every 256th beat
//   s_axis_fft_*               FFT results
//   r_axis_*                   forwarded results
module xfft_frame_feeder
    import xfft_feeder_pkg::*;
#(
    parameter int P_NFFT_LOG2 = 8,
    parameter int P_CFG_PAD   = 7
)
(
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 start,
    input  logic [15:0]          frame_num,
    input  logic                 fwd_inv,
    output logic                 busy,
    output logic                 done,
    output logic                 len_err,
    input  logic [31:0]          s_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    output logic [P_CFG_PAD:0]   m_axis_config_tdata,
    output logic                 m_axis_config_tvalid,
    input  logic                 m_axis_config_tready,
    output logic [31:0]          m_axis_data_tdata,
    output logic                 m_axis_data_tvalid,
    input  logic                 m_axis_data_tready,
    output logic                 m_axis_data_tlast,
    input  logic [63:0]          s_axis_fft_tdata,
    input  logic                 s_axis_fft_tvalid,
    output logic                 s_axis_fft_tready,
    input  logic                 s_axis_fft_tlast,
    output logic [63:0]          r_axis_tdata,
    output logic                 r_axis_tvalid,
    input  logic                 r_axis_tready,
    output logic                 r_axis_tlast
);

    localparam logic [P_NFFT_LOG2-1:0] LAST_BEAT = '1;
    localparam logic [FRAME_CNT_W-1:0] ONE_F     = {{(FRAME_CNT_W-1){1'b0}}, 1'b1};

    feeder_state_t          state, state_nxt;
    logic [FRAME_CNT_W-1:0] frame_num_q;
    logic [FRAME_CNT_W-1:0] frames_sent;
    logic [FRAME_CNT_W-1:0] frames_rcvd;
    logic [P_NFFT_LOG2-1:0] beat_cnt;
    logic [P_CFG_PAD:0]     cfg_word;
    logic                   fwd_inv_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   start_ok;
    logic                   data_hs;
    logic                   last_frame_sent;
    logic                   frame_tick;
    logic                   run_done;

    assign start_ok        = (state == IDLE) & start & (frame_num != '0);
    assign data_hs         = m_axis_data_tvalid & m_axis_data_tready;
    assign last_frame_sent = data_hs & m_axis_data_tlast & ((frames_sent + 1'b1) == frame_num_q);
    // Finish either when the count is already complete or when the final
    // result tlast lands this cycle, so done trails that handshake by one cycle.
    assign run_done        = (state == DRAIN) &
                             ((frames_rcvd == frame_num_q) |
                              (frame_tick & ((frames_rcvd + ONE_F) == frame_num_q)));

    // State register
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok)             state_nxt = CFG;
            CFG:     if (m_axis_config_tready) state_nxt = DATA;
            DATA:    if (last_frame_sent)      state_nxt = DRAIN;
            DRAIN:   if (run_done)             state_nxt = IDLE;
            default:                           state_nxt = IDLE;
        endcase
    end

    // Stream outputs
    always_comb begin
        m_axis_config_tvalid = 1'b0;
        m_axis_data_tvalid   = 1'b0;
        m_axis_data_tlast    = 1'b0;
        s_axis_tready        = 1'b0;
        case (state)
            CFG: begin
                m_axis_config_tvalid = 1'b1;
            end
            DATA: begin
                m_axis_data_tvalid = s_axis_tvalid;
                s_axis_tready      = m_axis_data_tready;
                m_axis_data_tlast  = (beat_cnt == LAST_BEAT);
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        cfg_word                  = '0;
        cfg_word[CFG_FWD_INV_BIT] = fwd_inv_q;
    end

    assign m_axis_config_tdata = cfg_word;
    assign m_axis_data_tdata   = s_axis_tdata;
    assign busy                = busy_q;
    assign done                = done_q;

    // Run registers and input-side counters
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            frame_num_q <= '0;
            fwd_inv_q   <= 1'b0;
            frames_sent <= '0;
            beat_cnt    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_ok) begin
                frame_num_q <= frame_num;
                fwd_inv_q   <= fwd_inv;
                frames_sent <= '0;
                beat_cnt    <= '0;
                busy_q      <= 1'b1;
            end
            if (data_hs) begin
                // Wraps naturally from the last beat back to 0.
                beat_cnt <= beat_cnt + 1'b1;
                if (m_axis_data_tlast) begin
                    frames_sent <= frames_sent + 1'b1;
                end
            end
            if (run_done) begin
                done_q <= 1'b1;
                busy_q <= 1'b0;
            end
        end
    end

    xfft_result_mon
`ifdef XFFT_FEEDER_LEN_CHECK_EN
        #(.P_NFFT_LOG2(P_NFFT_LOG2))
`endif
        u_result_mon (
        .aclk              (aclk),
        .areset            (areset),
        .count_en          (state != IDLE),
        .clear             (start_ok),
        .s_axis_fft_tdata  (s_axis_fft_tdata),
        .s_axis_fft_tvalid (s_axis_fft_tvalid),
        .s_axis_fft_tready (s_axis_fft_tready),
        .s_axis_fft_tlast  (s_axis_fft_tlast),
        .r_axis_tdata      (r_axis_tdata),
        .r_axis_tvalid     (r_axis_tvalid),
        .r_axis_tready     (r_axis_tready),
        .r_axis_tlast      (r_axis_tlast),
        .frames_rcvd       (frames_rcvd),
        .frame_tick        (frame_tick),
        .len_err           (len_err)
    );

endmodule
